// File: rtl/ide_xfer_sequencer.sv
// ide_xfer_sequencer
//   Hardware sequencer that sits between the AVR SRAM-style bus and the IDE
//   interface register/buffer port. It runs multi-block PIO/DMA data phases.
//   For each block it programs iopos/iotarget/iocontrol/status, polls the
//   interface flags until the block completes, and acknowledges the block.
//   It then asks firmware for a buffer refill or finishes the command. The
//   IDE port is shared between the CPU and the sequencer's own bus cycles.
//
//   Configuration macro: IDE_SEQ_DMA_EN. When it is defined, CTRL.DMA is
//   stored and selects DMA in iocontrol. When it is undefined, DMA is tied
//   to 0 and only PIO sequences are possible.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cpu_a/cpu_d_in/cpu_d_out  CPU address, write data, combinational read data
//   cpu_cs/cpu_oe/cpu_we      CPU strobes
//   cpu_wait, cpu_irq         CPU stall and interrupt
//   ide_a/ide_d_out/ide_d_in  IDE port address, write data, read data
//   ide_cs/ide_oe/ide_we      IDE port strobes
//   ide_wait, ide_irq         IDE port stall and interrupt
module ide_xfer_sequencer #(
    parameter logic [7:0] FINAL_STATUS_DEF = 8'h50,
    parameter logic [7:0] XFER_STATUS      = 8'h58
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] cpu_a,
    input  logic [7:0] cpu_d_in,
    output logic [7:0] cpu_d_out,
    input  logic       cpu_cs,
    input  logic       cpu_oe,
    input  logic       cpu_we,
    output logic       cpu_wait,
    output logic       cpu_irq,
    output logic [9:0] ide_a,
    output logic [7:0] ide_d_out,
    output logic       ide_cs,
    output logic       ide_oe,
    output logic       ide_we,
    input  logic [7:0] ide_d_in,
    input  logic       ide_wait,
    input  logic       ide_irq
);

    typedef enum logic [3:0] {
        S_IDLE, S_SET_POS, S_SET_TGT, S_SET_CTL, S_SET_STAT,
        S_POLL, S_GAP, S_ACK, S_STOP, S_FILL, S_FINAL
    } state_t;

    state_t     st_q, st_d;
    logic       dir_q, dir_d, dma_q, dma_d, ien_q, ien_d;
    logic [7:0] blklen_q, blklen_d, blkcnt_q, blkcnt_d, endst_q, endst_d;
    logic       busy_q, busy_d, fill_q, fill_d, done_q, done_d;
    logic       aborted_q, aborted_d;
    logic       abrt_q, abrt_d;            // current sequence is being aborted
    logic       hit_data_q, hit_data_d;    // last poll saw the data flag
    logic       hit_rst_q, hit_rst_d;      // last poll saw hrst/srst
    // Sequencer-side bus cycle, registered alongside the state it belongs to
    logic       bus_cs_q, bus_cs_d, bus_oe_q, bus_oe_d, bus_we_q, bus_we_d;
    logic [2:0] bus_a_q, bus_a_d;
    logic [7:0] bus_d_q, bus_d_d;

    logic seq_sel, seq_wr, cpu_ide, go_p, abort_p, cont_p;

    assign seq_sel = ~cpu_a[9] & cpu_a[4];
    assign seq_wr  = cpu_cs & cpu_we & seq_sel;
    assign cpu_ide = cpu_cs & (cpu_oe | cpu_we) & ~seq_sel;
    assign go_p    = seq_wr & (cpu_a[3:0] == 4'h0) & cpu_d_in[0];
    assign abort_p = seq_wr & (cpu_a[3:0] == 4'h0) & cpu_d_in[4];
    assign cont_p  = seq_wr & (cpu_a[3:0] == 4'h0) & cpu_d_in[5];

    always_comb begin
        st_d       = st_q;
        dir_d      = dir_q;
        dma_d      = dma_q;
        ien_d      = ien_q;
        blklen_d   = blklen_q;
        blkcnt_d   = blkcnt_q;
        endst_d    = endst_q;
        busy_d     = busy_q;
        fill_d     = fill_q;
        done_d     = done_q;
        aborted_d  = aborted_q;
        abrt_d     = abrt_q;
        hit_data_d = hit_data_q;
        hit_rst_d  = hit_rst_q;
        bus_cs_d   = 1'b0;
        bus_oe_d   = 1'b0;
        bus_we_d   = 1'b0;
        bus_a_d    = '0;
        bus_d_d    = '0;

        // CPU writes to the sequencer registers
        if (seq_wr) begin
            case (cpu_a[3:0])
                4'h0: begin
                    dir_d = cpu_d_in[1];
                    ien_d = cpu_d_in[3];
`ifdef IDE_SEQ_DMA_EN
                    dma_d = cpu_d_in[2];
`else
                    dma_d = 1'b0;
`endif
                end
                4'h1: blklen_d = cpu_d_in;
                4'h2: blkcnt_d = cpu_d_in;
                4'h3: begin
                    if (cpu_d_in[2]) done_d    = 1'b0;
                    if (cpu_d_in[3]) aborted_d = 1'b0;
                end
                4'h4: endst_d = cpu_d_in;
                default: ;
            endcase
        end

        // Sequencer state updates take priority over a same-cycle CPU write
        if (abort_p && st_q != S_IDLE) begin
            st_d      = S_STOP;
            abrt_d    = 1'b1;
            aborted_d = 1'b1;
            fill_d    = 1'b0;
        end else begin
            case (st_q)
                S_IDLE: begin
                    if (go_p && !abort_p) begin
                        if (blkcnt_q != 8'h00) begin
                            st_d   = S_SET_POS;
                            busy_d = 1'b1;
                        end else begin
                            st_d = S_FINAL;
                        end
                    end
                end
                S_SET_POS:  st_d = S_SET_TGT;
                S_SET_TGT:  st_d = S_SET_CTL;
                S_SET_CTL:  st_d = S_SET_STAT;
                S_SET_STAT: st_d = S_POLL;
                S_POLL: begin
                    if (!ide_wait) begin
                        st_d       = S_GAP;
                        hit_data_d = ide_d_in[5];
                        hit_rst_d  = ide_d_in[3] | ide_d_in[2];
                    end
                end
                S_GAP: begin
                    // A drive reset invalidates the block even if data is flagged
                    if (hit_rst_q) begin
                        st_d      = S_STOP;
                        abrt_d    = 1'b1;
                        aborted_d = 1'b1;
                    end else if (hit_data_q) begin
                        st_d = S_ACK;
                    end else begin
                        st_d = S_POLL;
                    end
                end
                S_ACK: begin
                    if (blkcnt_d != 8'h00) blkcnt_d = blkcnt_d - 8'd1;
                    st_d = S_STOP;
                end
                S_STOP: begin
                    if (abrt_q) begin
                        st_d   = S_IDLE;
                        busy_d = 1'b0;
                        abrt_d = 1'b0;
                    end else if (blkcnt_q != 8'h00) begin
                        st_d   = S_FILL;
                        fill_d = 1'b1;
                    end else begin
                        st_d = S_FINAL;
                    end
                end
                S_FILL: begin
                    if (cont_p) begin
                        st_d   = S_SET_POS;
                        fill_d = 1'b0;
                    end
                end
                S_FINAL: begin
                    st_d   = S_IDLE;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
                default: st_d = S_IDLE;
            endcase
        end

        // Bus cycle for the state being entered
        case (st_d)
            S_SET_POS:  begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_a_d = 3'd3; end
            S_SET_TGT:  begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_a_d = 3'd5; bus_d_d = blklen_d; end
            S_SET_CTL:  begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_a_d = 3'd2;
                              bus_d_d = {5'b0, dma_d, ~dma_d, dir_d}; end
            S_SET_STAT: begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_a_d = 3'd0; bus_d_d = XFER_STATUS; end
            S_POLL:     begin bus_cs_d = 1'b1; bus_oe_d = 1'b1; bus_a_d = 3'd6; end
            S_ACK:      begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_a_d = 3'd6; bus_d_d = 8'h20; end
            S_STOP:     begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_a_d = 3'd2; end
            S_FINAL:    begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_a_d = 3'd0; bus_d_d = endst_d; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q       <= S_IDLE;
            dir_q      <= 1'b0;
            dma_q      <= 1'b0;
            ien_q      <= 1'b0;
            blklen_q   <= '0;
            blkcnt_q   <= '0;
            endst_q    <= FINAL_STATUS_DEF;
            busy_q     <= 1'b0;
            fill_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            abrt_q     <= 1'b0;
            hit_data_q <= 1'b0;
            hit_rst_q  <= 1'b0;
            bus_cs_q   <= 1'b0;
            bus_oe_q   <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_a_q    <= '0;
            bus_d_q    <= '0;
        end else begin
            st_q       <= st_d;
            dir_q      <= dir_d;
            dma_q      <= dma_d;
            ien_q      <= ien_d;
            blklen_q   <= blklen_d;
            blkcnt_q   <= blkcnt_d;
            endst_q    <= endst_d;
            busy_q     <= busy_d;
            fill_q     <= fill_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            abrt_q     <= abrt_d;
            hit_data_q <= hit_data_d;
            hit_rst_q  <= hit_rst_d;
            bus_cs_q   <= bus_cs_d;
            bus_oe_q   <= bus_oe_d;
            bus_we_q   <= bus_we_d;
            bus_a_q    <= bus_a_d;
            bus_d_q    <= bus_d_d;
        end
    end

    // Port arbitration: the sequencer owns any cycle it has a bus cycle for.
    // Everything is held quiet while rst is high so a reset landing mid-block
    // never writes the interface.
    always_comb begin
        ide_a     = '0;
        ide_d_out = '0;
        ide_cs    = 1'b0;
        ide_oe    = 1'b0;
        ide_we    = 1'b0;
        cpu_wait  = 1'b0;
        if (!rst) begin
            if (bus_cs_q) begin
                ide_a     = {7'b0, bus_a_q};
                ide_d_out = bus_d_q;
                ide_cs    = 1'b1;
                ide_oe    = bus_oe_q;
                ide_we    = bus_we_q;
                cpu_wait  = cpu_ide;
            end else if (cpu_ide) begin
                ide_a     = cpu_a;
                ide_d_out = cpu_d_in;
                ide_cs    = 1'b1;
                ide_oe    = cpu_oe;
                ide_we    = cpu_we;
                cpu_wait  = ide_wait;
            end
        end
    end

    always_comb begin
        cpu_d_out = ide_d_in;
        if (seq_sel) begin
            case (cpu_a[3:0])
                4'h0:    cpu_d_out = {5'b0, ien_q, dma_q, dir_q};
                4'h1:    cpu_d_out = blklen_q;
                4'h2:    cpu_d_out = blkcnt_q;
                4'h3:    cpu_d_out = {4'b0, aborted_q, done_q, fill_q, busy_q};
                4'h4:    cpu_d_out = endst_q;
                default: cpu_d_out = '0;
            endcase
        end
    end

    assign cpu_irq = ~rst & ((ide_irq & ~busy_q) | (ien_q & (fill_q | done_q | aborted_q)));

endmodule
